// File: rtl/vga_fb_pkg.sv
// Shared constants, slot encoding and pixel unpack helper for the VGA framebuffer scheduler.
package vga_fb_pkg;

  localparam int H_ACTIVE     = 800;
  localparam int V_ACTIVE     = 480;
  localparam int PIX_PER_WORD = 16;
  localparam int ADDR_W       = 15;
  localparam int FIFO_DEPTH   = 4;
  localparam int WORD_W       = 48;
  localparam int FRAME_WORDS  = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } slot_e;

  function automatic logic [2:0] pix_slice(input logic [WORD_W-1:0] word, input logic [3:0] idx);
    logic [5:0] lsb;
    lsb = 6'(idx) * 6'd3;
    return word[lsb +: 3];
  endfunction

endpackage

// File: rtl/vga_fb_prefetch_fifo.sv
// Small synchronous prefetch FIFO with flush; head is visible combinationally.
module vga_fb_prefetch_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = WORD_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // a full FIFO may accept a push only when the head leaves in the same cycle
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/vga_fb_scheduler.sv
// Arbitrates the framebuffer RAM between scanout prefetch and the pixel writer.
// Underrun statistics are present only when VGA_FB_UNDERRUN_STATS_EN is defined.
module vga_fb_scheduler
  import vga_fb_pkg::*;
(
  input  logic              CLOCK_PIXEL,
  input  logic              RESET_N,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [2:0]        pix_rgb,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int SKW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic              r_fetch_act;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [1:0]        r_inf_v;
  logic [1:0]        r_inf_disc;
  logic [3:0]        r_pix_idx;
  logic [SKW-1:0]    r_skip;
  logic [2:0]        r_pix_rgb;

  slot_e             w_slot;
  logic [CW-1:0]     w_fifo_cnt;
  logic              w_fifo_empty;
  logic [WORD_W-1:0] w_head;
  logic [CW:0]       w_used;
  logic              w_credit;
  logic              w_arrive;
  logic              w_skip_take;
  logic              w_skip_add;
  logic              w_push;
  logic              w_wrap;
  logic              w_pop;

  // discard-tagged reads still hold a credit until they return
  assign w_used   = (CW+1)'(w_fifo_cnt) + (CW+1)'(r_inf_v[0]) + (CW+1)'(r_inf_v[1]);
  assign w_credit = (w_used < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    w_slot = IDLE;
    if (RESET_N) begin
      if (r_fetch_act && w_credit && !frame_start) w_slot = FETCH;
      else if (wr_req)                             w_slot = WRITE;
    end
  end

  assign mem_en    = (w_slot != IDLE);
  assign mem_we    = (w_slot == WRITE);
  assign wr_ack    = (w_slot == WRITE);
  assign mem_addr  = (w_slot == FETCH) ? r_fetch_addr :
                     (w_slot == WRITE) ? wr_addr      : '0;
  assign mem_wdata = (w_slot == WRITE) ? wr_data : '0;

  assign w_arrive    = r_inf_v[1] && !r_inf_disc[1];
  assign w_skip_take = w_arrive && (r_skip != '0);
  assign w_push      = w_arrive && (r_skip == '0) && !frame_start;
  assign w_wrap      = pix_req && (r_pix_idx == 4'd15);
  assign w_pop       = w_wrap && !w_fifo_empty;
  // a word boundary passed while starved: the late word must be dropped on arrival
  assign w_skip_add  = w_wrap && w_fifo_empty && (r_skip != SKW'(FIFO_DEPTH));

  vga_fb_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .i_clk   (CLOCK_PIXEL),
    .i_rst_n (RESET_N),
    .i_flush (frame_start),
    .i_push  (w_push),
    .i_wdata (mem_rdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  always_ff @(posedge CLOCK_PIXEL) begin
    if (!RESET_N) begin
      r_fetch_act  <= 1'b0;
      r_fetch_addr <= '0;
      r_inf_v      <= '0;
      r_inf_disc   <= '0;
      r_pix_idx    <= '0;
      r_skip       <= '0;
      r_pix_rgb    <= '0;
    end else begin
      r_inf_v    <= {r_inf_v[0], (w_slot == FETCH)};
      r_inf_disc <= frame_start ? 2'b10 : {r_inf_disc[0], 1'b0};
      r_pix_rgb  <= (pix_req && !w_fifo_empty) ? pix_slice(w_head, r_pix_idx) : 3'd0;
      if (frame_start) begin
        r_fetch_act  <= 1'b1;
        r_fetch_addr <= '0;
        r_pix_idx    <= '0;
        r_skip       <= '0;
      end else begin
        if (pix_req) r_pix_idx <= r_pix_idx + 4'd1;
        r_skip <= r_skip + SKW'(w_skip_add) - SKW'(w_skip_take);
        if (w_slot == FETCH) begin
          if (r_fetch_addr == LAST_ADDR) r_fetch_act  <= 1'b0;
          else                           r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign pix_rgb = r_pix_rgb;

`ifdef VGA_FB_UNDERRUN_STATS_EN
  logic        r_underrun;
  logic [15:0] r_underrun_cnt;
  logic        w_under;

  assign w_under = pix_req && w_fifo_empty;

  always_ff @(posedge CLOCK_PIXEL) begin
    if (!RESET_N) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (w_under) begin
      r_underrun <= 1'b1;
      if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;
`else
  assign underrun     = 1'b0;
  assign underrun_cnt = '0;
`endif

endmodule

// File: doc/vga_fb_scheduler.md
# vga_fb_scheduler

Schedules a single-port 3-bit-RGB framebuffer RAM between the 800x480 scanout path and a pixel-writer port, all in the CLOCK_PIXEL domain. The display path prefetches 48-bit words (16 pixels each) into a small FIFO ahead of the timing generator's pixel requests and unpacks them to VGA_RED/GREEN/BLUE. The writer is granted every memory slot the prefetcher does not need. The block sits between the VGA timing generator and the framebuffer RAM inside vga_demo-class top levels.

## Interface
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- PIX_PER_WORD, 16, pixels packed per memory word (3 bits each)
- ADDR_W, 15, word address width (24000 words per frame)
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two)
- CLOCK_PIXEL  in  1  pixel clock, sole clock
- RESET_N  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse, at least FIFO_DEPTH+3 cycles before the first active pixel of a frame
- pix_req  in  1  timing generator consumes one active pixel this cycle
- pix_rgb  out  3  {R,G,B} pixel, registered
- wr_req  in  1  writer requests a word write
- wr_addr  in  ADDR_W  writer word address
- wr_data  in  48  writer word, pixel 0 in [2:0]
- wr_ack  out  1  combinational; write issued this cycle
- mem_en, mem_we  out  1 each  RAM strobe and write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  48  RAM write data
- mem_rdata  in  48  RAM read data, valid exactly 2 cycles after a read strobe
- underrun  out  1  sticky underrun flag
- underrun_cnt  out  16  saturating underrun pixel count

## Operation
- Slot arbitration each cycle: FETCH when the frame has words left to fetch and occupancy + in-flight < FIFO_DEPTH; otherwise WRITE if wr_req; otherwise IDLE (mem_en=0). Fetch always wins. wr_ack=1 only in WRITE cycles.
- The fetch address starts at 0 on frame_start and increments per fetch up to H_ACTIVE*V_ACTIVE/PIX_PER_WORD-1. After the last word, fetching stops until the next frame_start.
- In-flight tracking uses a 2-stage valid shift register. Returning data is pushed into the FIFO unless the entry is tagged discard.
- Unpack: a 4-bit pixel index selects bits [3i+2:3i] of the FIFO head. When the index wraps from 15 to 0, the head is popped.
- Underrun: pix_req with the FIFO empty outputs 0 and still advances the index. A wrap during underrun increments a skip counter (max FIFO_DEPTH) instead of popping. Each nonzero skip discards the next arriving word, which preserves alignment.
- frame_start, including mid-frame: flush the FIFO, tag in-flight reads as discard, clear the index and skip counter, reset the fetch address to 0. A write issued in the same cycle still completes.
- RESET_N low: FIFO, in-flight valids, index, skip counter, and address cleared. Outputs: pix_rgb=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ack=0, underrun=0, underrun_cnt=0. Read data returning after reset is ignored.
- No coherency: a write to an already-prefetched word is not visible until the next frame.

## Timing
- pix_rgb updates 1 cycle after pix_req. It is 0 in any cycle following pix_req=0.
- Read-to-FIFO latency: strobe at cycle t gives the FIFO push at t+2, and the word is poppable at t+3.
- After frame_start the FIFO is full within FIFO_DEPTH+3 cycles, provided no reset intervenes.
- Steady state: 1 fetch per 16 pixels, leaving at least 15/16 of slots for the writer.
- A write is issued in the wr_ack cycle. mem_* are combinational from the arbiter decision, so the RAM samples them at the next edge.
- Simultaneous pop and push with the FIFO full is legal. Push with the FIFO full otherwise never occurs, because of the credit rule.

## Configuration
- VGA_FB_UNDERRUN_STATS_EN defined:
  - underrun is set on the first underrun pixel and cleared only by reset.
  - underrun_cnt increments per underrun pixel and saturates at 16'hFFFF.
- Undefined: both outputs are tied to 0 and the counter logic is absent. Underrun pixel behaviour is unchanged.

## Structure
- Shared package vga_fb_pkg holds:
  - H_ACTIVE, V_ACTIVE, PIX_PER_WORD, ADDR_W defaults.
  - FRAME_WORDS constant.
  - Slot-state encoding: IDLE, FETCH, WRITE.
  - Pixel bit-slice helper.
- One sub-module: vga_fb_prefetch_fifo (FIFO_DEPTH x 48, synchronous, flush input, count output).

## Test plan
- Reset, then frame_start, no pix_req: exactly 4 reads at addresses 0..3, mem_we=0, then IDLE. FIFO count is 4 at cycle 7.
- RAM word k = pattern with pixel i = (i+k)%8; 800 pix_req per line over 480 lines: pix_rgb matches the pattern with no underrun, and 24000 reads occur.
- wr_req held high throughout scanout: wr_ack never coincides with a fetch, writes land at the given addresses, and the writer gets at least 15 of every 16 slots.
- Stall fetch by pre-filling credits, then issue 20 pix_req with the FIFO empty: 20 black pixels, and underrun_cnt=20 with the macro (0 without). Subsequent pixels stay aligned to word boundaries.
- Mid-frame frame_start with 2 reads in flight: those returns are discarded, and the next pixels come from word 0.
- RESET_N low for 1 cycle with reads in flight: all outputs 0 next cycle, and returning data is not pushed.
